pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of the data payload (operands, immediates, PC concatenated).
REQ-002 SHALL have parameter CTRL_W, default 9, width of the control payload (WB 3 + MEM 2 + EX 4).
REQ-003 SHALL have parameter ZERO_DATA_ON_BUBBLE, default 1; when 1, the data payload reads zero whenever the stage is empty.
REQ-004 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous kill of all held and incoming entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 in_data  input  DATA_W  upstream data payload.
REQ-012 out_valid  output  1  entry present to downstream.
REQ-013 out_ready  input  1  downstream accepts this cycle.
REQ-014 out_ctrl  output  CTRL_W  control payload of head entry.
REQ-015 out_data  output  DATA_W  data payload of head entry.
REQ-016 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 SHALL hold two entries: main (drives outputs) and skid (overflow); each has a valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, driven directly from a register with no combinational path from out_ready.
REQ-019 Accept SHALL occur when in_valid=1 and in_ready=1; drain SHALL occur when out_valid=1 and out_ready=1.
REQ-020 out_valid SHALL equal main_valid; out_ctrl SHALL be zero whenever main_valid=0.
REQ-021 When main is empty or draining: main SHALL load skid if skid_valid=1, else the accepted entry, else become empty.
REQ-022 When main holds and does not drain: an accepted entry SHALL go to skid.
REQ-023 When skid moves to main, skid SHALL become empty in the same edge (no accept is possible that cycle per REQ-018).
REQ-024 Latency SHALL be 1 cycle from accept to out_valid when unstalled; sustained throughput SHALL be 1 entry/cycle.
REQ-025 Entries SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-026 flush=1 SHALL empty main and skid, zero their ctrl (and data if ZERO_DATA_ON_BUBBLE=1), and discard any same-cycle accept; in_ready=1 next cycle.
REQ-027 flush SHALL NOT alter stall_cnt.
REQ-028 stall_cnt SHALL increment by 1 per stall cycle and hold at 2^CNT_W-1.
REQ-029 Payload registers SHALL load only on a move (REQ-021/022); otherwise hold.

Reset
REQ-030 reset=1 SHALL force, at the next edge: main_valid=0, skid_valid=0, all payload registers=0, stall_cnt=0, hence in_ready=1, out_valid=0, out_ctrl=0, out_data=0.
REQ-031 reset SHALL take priority over flush and every handshake; an entry presented during reset SHALL be discarded.
REQ-032 The initial (power-up) state SHALL equal the reset state.

Structure
REQ-033 Field widths WB_W=3, MEM_W=2, EX_W=4, CTRL_W=WB_W+MEM_W+EX_W and the default DATA_W SHALL live in shared package pipe_pkg.
REQ-034 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W, ports clock, reset, inc, count).
REQ-035 The block SHALL be instantiable for every inter-stage boundary of the 6-stage pipeline by parameters alone.

Verification
REQ-036 Stream: in_valid=1 for 8 cycles with data 1..8, out_ready=1 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready always 1.
REQ-037 Backpressure: accept A=0x11, B=0x22 with out_ready=0 -> in_ready=0 after B, stall_cnt increments each cycle; raise out_ready -> A then B in order, in_ready=1 one cycle after A drains.
REQ-038 Flush with both entries full and in_valid=1 (C=0x33) -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; C never appears.
REQ-039 Reset mid-stall with stall_cnt=5 -> next cycle stall_cnt=0, all outputs zero, in_ready=1.
REQ-040 Saturation with CNT_W=3: hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt stops at 7.
REQ-041 Random valid/ready over 10000 cycles against a FIFO model -> zero order, loss or duplication errors; in_ready never 0 with skid empty.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline field widths and skid-stage move encoding.
package pipe_pkg;

    localparam int unsigned WB_W   = 3;
    localparam int unsigned MEM_W  = 2;
    localparam int unsigned EX_W   = 4;
    localparam int unsigned CTRL_W = WB_W + MEM_W + EX_W;
    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic [WB_W-1:0]  wb;
        logic [MEM_W-1:0] mem;
        logic [EX_W-1:0]  ex;
    } ctrl_t;

    // What the main (output) entry does on the next edge.
    typedef enum logic [1:0] {
        MV_HOLD      = 2'd0,
        MV_FROM_SKID = 2'd1,
        MV_FROM_IN   = 2'd2,
        MV_EMPTY     = 2'd3
    } main_mv_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline register: fully registered ready, 1-cycle latency,
// full throughput, flush and saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W              = pipe_pkg::DATA_W,
    parameter int unsigned CTRL_W              = pipe_pkg::CTRL_W,
    parameter bit          ZERO_DATA_ON_BUBBLE = 1'b1,
    parameter int unsigned CNT_W               = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    import pipe_pkg::*;

    logic              r_main_valid;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic              w_accept;
    logic              w_drain;
    logic              w_stall;
    main_mv_e          w_main_mv;
    logic              w_skid_load;
    logic              w_skid_clear;

    assign w_accept = in_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & out_ready;
    assign w_stall  = r_main_valid & ~out_ready;

    // Move selection: main refills from skid first so order is preserved.
    always_comb begin
        w_main_mv    = MV_HOLD;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (!r_main_valid || w_drain) begin
            if (r_skid_valid) begin
                w_main_mv    = MV_FROM_SKID;
                w_skid_clear = 1'b1;
            end else if (w_accept) begin
                w_main_mv = MV_FROM_IN;
            end else begin
                w_main_mv = MV_EMPTY;
            end
        end else if (w_accept) begin
            w_skid_load = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            if (ZERO_DATA_ON_BUBBLE) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            case (w_main_mv)
                MV_FROM_SKID: begin
                    r_main_valid <= 1'b1;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_main_data  <= r_skid_data;
                end
                MV_FROM_IN: begin
                    r_main_valid <= 1'b1;
                    r_main_ctrl  <= in_ctrl;
                    r_main_data  <= in_data;
                end
                MV_EMPTY: begin
                    r_main_valid <= 1'b0;
                    r_main_ctrl  <= '0;
                    if (ZERO_DATA_ON_BUBBLE) begin
                        r_main_data <= '0;
                    end
                end
                default: ;
            endcase
            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_ctrl  <= in_ctrl;
                r_skid_data  <= in_data;
            end else if (w_skid_clear) begin
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
                if (ZERO_DATA_ON_BUBBLE) begin
                    r_skid_data <= '0;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (w_stall),
        .count (stall_cnt)
    );

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed scenarios plus random traffic.
module tb_pipe_stage_skid;

    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 9;
    localparam int unsigned CNTW = 3;
    localparam int          SMAX = (1 << CNTW) - 1;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [CW-1:0]   in_ctrl = '0;
    logic [DW-1:0]   in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [CW-1:0]   out_ctrl;
    logic [DW-1:0]   out_data;
    logic [CNTW-1:0] stall_cnt;

    ent_t exp_q[$];
    int   pend    = 0;
    bit   kill    = 1'b0;
    bit   mon_on  = 1'b0;
    int   stall_m = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    pipe_stage_skid #(
        .DATA_W              (DW),
        .CTRL_W              (CW),
        .ZERO_DATA_ON_BUBBLE (1'b1),
        .CNT_W               (CNTW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; records the expected accept in the scoreboard.
    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit rdy, input bit fl, input bit rs);
        @(negedge clock);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
        flush     = fl;
        reset     = rs;
        #1;
        kill = fl | rs;
        pend = 0;
        if (v && (exp_q.size() < 2) && !kill) begin
            exp_q.push_back('{c: c, d: d});
            pend = 1;
        end
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: occupancy-derived handshake checks, head compare, stall model.
    initial begin
        int n;
        wait (mon_on);
        forever begin
            @(negedge clock);
            #2;
            if (mon_on) begin
                n = exp_q.size() - pend;
                chk("in_ready", in_ready, 32'(n < 2));
                chk("out_valid", out_valid, 32'(n > 0));
                chk("stall_cnt", stall_cnt, 32'(stall_m));
                if (n > 0) begin
                    chk("out_ctrl", out_ctrl, 32'(exp_q[0].c));
                    chk("out_data", out_data, 32'(exp_q[0].d));
                    if (out_ready && !kill) void'(exp_q.pop_front());
                end else begin
                    chk("bubble_ctrl", out_ctrl, 32'd0);
                    chk("bubble_data", out_data, 32'd0);
                end
                if (reset) stall_m = 0;
                else if (n > 0 && !out_ready && stall_m < SMAX) stall_m++;
                if (kill) exp_q.delete();
            end
        end
    end

    initial begin
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        mon_on = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("rst_out_valid", out_valid, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);
        chk("rst_stall", stall_cnt, 32'd0);

        // Streaming at full rate.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_in_ready", in_ready, 32'd1);
        end
        idle(1'b1, 2);

        // Backpressure: A, B held, then drained in order.
        drive(1'b1, 16'h0011, 9'h011, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0022, 9'h022, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready_low", in_ready, 32'd0);
        idle(1'b0, 3);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("bp_in_ready_back", in_ready, 32'd1);
        idle(1'b1, 2);

        // Flush with both entries full and C presented.
        drive(1'b1, 16'h000A, 9'h00A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 9'h00B, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h0033, 9'h033, 1'b0, 1'b1, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_out_valid", out_valid, 32'd0);
        chk("flush_out_ctrl", out_ctrl, 32'd0);
        chk("flush_out_data", out_data, 32'd0);
        chk("flush_in_ready", in_ready, 32'd1);
        idle(1'b1, 2);

        // Reset mid-stall at stall_cnt=5; entry during reset is discarded.
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0044, 9'h044, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 5);
        drive(1'b1, 16'h0055, 9'h055, 1'b0, 1'b0, 1'b1);
        chk("pre_reset_stall", stall_cnt, 32'd5);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_stall", stall_cnt, 32'd0);
        chk("mid_rst_valid", out_valid, 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_in_ready", in_ready, 32'd1);

        // Saturation at 2^CNTW-1.
        drive(1'b1, 16'h0066, 9'h066, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 10);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        chk("stall_saturate", stall_cnt, 32'(SMAX));
        idle(1'b1, 2);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(($urandom % 4) != 0, DW'($urandom), CW'($urandom),
                  ($urandom % 3) != 0, ($urandom % 100) == 0, ($urandom % 1000) == 0);
        end
        idle(1'b1, 4);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
